// File: rtl/ad9231_capture_if.sv
// AD9231 capture bus: ADC pins on one side, host control and
// window readback on the other.
interface ad9231_capture_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 10
);
   logic [DATA_W-1:0]   adc_a;
   logic [DATA_W-1:0]   adc_b;
   logic                adc_or;
   logic                arm;
   logic                force_trig;
   logic                trig_ch;
   logic                trig_edge;
   logic [DATA_W-1:0]   trig_level;
   logic [ADDR_W-1:0]   pre_len;
   logic [ADDR_W-1:0]   rd_addr;
   logic [2*DATA_W-1:0] rd_data;
   logic                ready;
   logic                busy;
   logic                done;
   logic                ovr;
   logic [ADDR_W-1:0]   trig_pos;

   modport master (
      output adc_a, adc_b, adc_or,
      output arm, force_trig,
      output trig_ch, trig_edge, trig_level,
      output pre_len, rd_addr,
      input  rd_data, ready, busy, done,
      input  ovr, trig_pos
   );

   modport slave (
      input  adc_a, adc_b, adc_or,
      input  arm, force_trig,
      input  trig_ch, trig_edge, trig_level,
      input  pre_len, rd_addr,
      output rd_data, ready, busy, done,
      output ovr, trig_pos
   );
endinterface

// File: rtl/ad9231_capture.sv
// AD9231 dual-channel capture: input conversion, level/edge
// trigger and a pre/post-trigger window in a circular RAM.
module ad9231_capture #(
   parameter int DATA_W     = 12,
   parameter int ADDR_W     = 10,
   parameter int CFG_WAIT   = 20000,
   parameter int OFFSET_BIN = 1
) (
   input  logic            clk,
   input  logic            rstb,
   ad9231_capture_if.slave bus
);
   localparam int   DEPTH = 1 << ADDR_W;
   localparam int   CW    = $clog2(CFG_WAIT + 1);
   localparam logic INV   = (OFFSET_BIN != 0);

   typedef enum logic [2:0] {
      WAIT_CFG, IDLE, PRE, ARMED, POST, DONE
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0]   s1_a, s1_b, s2_a, s2_b, s3;
   logic                s1_or, s2_or;
   logic [CW-1:0]       cfg_cnt;
   logic [ADDR_W-1:0]   wptr, cnt, pre_q;
   logic [ADDR_W-1:0]   start_addr, trig_q, rd_phys;
   logic                ovr_q;
   logic [2*DATA_W-1:0] rd_q;
   logic [2*DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0]   s2_t;
   logic                rise, fall, fire, take_arm, we;
   logic                cfg_end, pre_end, post_end, busy;

   assign s2_t = bus.trig_ch ? s2_b : s2_a;

   assign rise = ($signed(s3) < $signed(bus.trig_level))
              && ($signed(s2_t) >= $signed(bus.trig_level));
   assign fall = ($signed(s3) > $signed(bus.trig_level))
              && ($signed(s2_t) <= $signed(bus.trig_level));

   // ~pre_q is the count of writes still owed after the trigger sample
   assign cfg_end  = (cfg_cnt == CW'(CFG_WAIT - 1));
   assign pre_end  = (cnt == pre_q - 1'b1);
   assign post_end = (cnt == ~pre_q - 1'b1);
   assign busy     = state inside {PRE, ARMED, POST};

   always_comb begin
      state_nxt = state;
      fire      = 1'b0;
      take_arm  = 1'b0;
      we        = 1'b0;
      unique case (state)
         WAIT_CFG: if (cfg_end) state_nxt = IDLE;
         IDLE, DONE: begin
            if (bus.arm) begin
               take_arm  = 1'b1;
               state_nxt = (bus.pre_len == '0) ? ARMED : PRE;
            end
         end
         PRE: begin
            we = 1'b1;
            if (pre_end) state_nxt = ARMED;
         end
         ARMED: begin
            we   = 1'b1;
            fire = bus.force_trig | (bus.trig_edge ? fall : rise);
            if (fire) state_nxt = (&pre_q) ? DONE : POST;
         end
         POST: begin
            we = 1'b1;
            if (post_end) state_nxt = DONE;
         end
         default: state_nxt = WAIT_CFG;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state      <= WAIT_CFG;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_or      <= 1'b0;
         s2_a       <= '0;
         s2_b       <= '0;
         s2_or      <= 1'b0;
         s3         <= '0;
         cfg_cnt    <= '0;
         wptr       <= '0;
         cnt        <= '0;
         pre_q      <= '0;
         start_addr <= '0;
         trig_q     <= '0;
         ovr_q      <= 1'b0;
      end else begin
         state <= state_nxt;
         s1_a  <= bus.adc_a;
         s1_b  <= bus.adc_b;
         s1_or <= bus.adc_or;
         s2_a  <= {s1_a[DATA_W-1] ^ INV, s1_a[DATA_W-2:0]};
         s2_b  <= {s1_b[DATA_W-1] ^ INV, s1_b[DATA_W-2:0]};
         s2_or <= s1_or;
         s3    <= s2_t;
         if (state == WAIT_CFG && !cfg_end)
            cfg_cnt <= cfg_cnt + 1'b1;
         if (we) wptr <= wptr + 1'b1;
         if (take_arm) begin
            pre_q <= bus.pre_len;
            cnt   <= '0;
            ovr_q <= 1'b0;
         end else begin
            if (fire)    cnt <= '0;
            else if (we) cnt <= cnt + 1'b1;
            if (busy && s2_or) ovr_q <= 1'b1;
         end
         if (fire) begin
            start_addr <= wptr - pre_q;
            trig_q     <= pre_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[wptr] <= {s2_a, s2_b};
   end

   assign rd_phys = start_addr + bus.rd_addr;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) rd_q <= '0;
      else       rd_q <= mem[rd_phys];
   end

   assign bus.ready    = (state != WAIT_CFG);
   assign bus.busy     = busy;
   assign bus.done     = (state == DONE);
   assign bus.ovr      = ovr_q;
   assign bus.trig_pos = trig_q;
   assign bus.rd_data  = (state == DONE) ? rd_q : '0;
endmodule

// File: tb/tb_ad9231_capture.sv
// Bench for ad9231_capture: directed scenarios and random captures
// checked against a window-level reference model.
module tb_ad9231_capture;
   localparam int DW    = 12;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;
   localparam int CFG   = 40;
   localparam int NG    = 3100;
   localparam int AK    = 4;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   arm2  = -1;

   logic [DW-1:0]   ga [NG];
   logic [DW-1:0]   gb [NG];
   logic            gor [NG];
   logic            gf [NG];
   logic [2*DW-1:0] expw [DEPTH];

   ad9231_capture_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   ad9231_capture #(
      .DATA_W(DW), .ADDR_W(AW),
      .CFG_WAIT(CFG), .OFFSET_BIN(1)
   ) dut (
      .clk(clk),
      .rstb(rstb),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // offset binary to two's complement
   function automatic logic [DW-1:0] tc(input logic [DW-1:0] x);
      return {~x[DW-1], x[DW-2:0]};
   endfunction

   function automatic bit crosses(input bit edg,
                                  input logic [DW-1:0] p,
                                  input logic [DW-1:0] c,
                                  input logic [DW-1:0] lvl);
      int ip, ic, il;
      ip = $signed(tc(p));
      ic = $signed(tc(c));
      il = $signed(lvl);
      return edg ? (ip > il && ic <= il)
                 : (ip < il && ic >= il);
   endfunction

   task automatic clear_gen();
      for (int k = 0; k < NG; k++) begin
         ga[k]  = '0;
         gb[k]  = '0;
         gor[k] = 1'b0;
         gf[k]  = 1'b0;
      end
      arm2 = -1;
   endtask

   task automatic rand_gen();
      for (int k = 0; k < NG; k++) begin
         ga[k]  = DW'($urandom_range(0, 4095));
         gb[k]  = DW'($urandom_range(0, 4095));
         gor[k] = ($urandom_range(0, 499) == 0);
      end
   endtask

   task automatic rd(input int a, output logic [2*DW-1:0] d);
      bus.rd_addr = AW'(a);
      tick();
      d = bus.rd_data;
   endtask

   // Sample g[k] is on the pins at edge k; arm lands on edge AK.
   task automatic capture(input string nm, input int pre,
                          input bit ch, input bit edg,
                          input logic [DW-1:0] lvl);
      int js, ws, de;
      logic eo;
      logic [DW-1:0] p, c;
      js = -1;
      for (int j = AK + pre - 1; j < NG - 2 && js < 0; j++) begin
         p = ch ? gb[j-1] : ga[j-1];
         c = ch ? gb[j] : ga[j];
         if (gf[j+2] || crosses(edg, p, c, lvl)) js = j;
      end
      if (js < 0) begin
         $display("FAIL %s_model: no trigger in stimulus", nm);
         $fatal(1, "stimulus without trigger");
      end
      ws = js - pre;
      de = ws + DEPTH + 1;
      for (int i = 0; i < DEPTH; i++)
         expw[i] = {tc(ga[ws+i]), tc(gb[ws+i])};
      eo = 1'b0;
      for (int j = AK - 1; j <= ws + DEPTH - 1; j++)
         eo = eo | gor[j];

      bus.trig_ch    = ch;
      bus.trig_edge  = edg;
      bus.trig_level = lvl;
      bus.pre_len    = AW'(pre);
      for (int k = 0; k <= de + 1; k++) begin
         bus.adc_a      = ga[k];
         bus.adc_b      = gb[k];
         bus.adc_or     = gor[k];
         bus.arm        = (k == AK) || (k == arm2);
         bus.force_trig = gf[k];
         tick();
         if (k == AK) begin
            chk({nm, "_arm_busy"}, 32'(bus.busy), 1);
            chk({nm, "_arm_done"}, 32'(bus.done), 0);
            chk({nm, "_arm_ovr"}, 32'(bus.ovr), 0);
            chk({nm, "_arm_rd0"}, 32'(bus.rd_data), 0);
         end
         if (k == de - 1)
            chk({nm, "_done_early"}, 32'(bus.done), 0);
         if (k == de) begin
            chk({nm, "_done"}, 32'(bus.done), 1);
            chk({nm, "_busy_end"}, 32'(bus.busy), 0);
         end
      end
      bus.arm        = 1'b0;
      bus.force_trig = 1'b0;
      bus.adc_or     = 1'b0;
      chk({nm, "_trig_pos"}, 32'(bus.trig_pos), 32'(pre));
      chk({nm, "_ovr"}, 32'(bus.ovr), 32'(eo));
      for (int i = 0; i < DEPTH; i++) begin
         bus.rd_addr = AW'(i);
         tick();
         chk({nm, "_win"}, 32'(bus.rd_data), 32'(expw[i]));
      end
   endtask

   initial begin
      logic [2*DW-1:0] d;
      int pre;
      bus.adc_a      = '0;
      bus.adc_b      = '0;
      bus.adc_or     = 1'b0;
      bus.arm        = 1'b1;
      bus.force_trig = 1'b0;
      bus.trig_ch    = 1'b0;
      bus.trig_edge  = 1'b0;
      bus.trig_level = '0;
      bus.pre_len    = '0;
      bus.rd_addr    = '0;
      repeat (3) tick();
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_ready", 32'(bus.ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ovr", 32'(bus.ovr), 0);
      chk("rst_trig_pos", 32'(bus.trig_pos), 0);

      // arm held high through the configuration wait
      rstb = 1'b1;
      for (int n = 1; n <= CFG + 1; n++) begin
         tick();
         if (n < CFG) chk("cfg_ready_low", 32'(bus.ready), 0);
         if (n == CFG) chk("cfg_ready_high", 32'(bus.ready), 1);
         if (n <= CFG) chk("cfg_busy_low", 32'(bus.busy), 0);
         else chk("cfg_first_arm", 32'(bus.busy), 1);
      end
      bus.arm        = 1'b0;
      bus.force_trig = 1'b1;
      tick();
      bus.force_trig = 1'b0;
      for (int n = 0; n < 2000 && !bus.done; n++) tick();
      chk("cfg_cap_done", 32'(bus.done), 1);
      chk("cfg_cap_trig_pos", 32'(bus.trig_pos), 0);

      clear_gen();
      rand_gen();
      for (int k = 0; k < NG; k++) begin
         ga[k]  = DW'(k);
         gor[k] = 1'b0;
      end
      capture("ramp", 100, 1'b0, 1'b0, 12'h000);
      rd(100, d);
      chk("ramp_trig_sample", 32'(d[23:12]), 32'h000);
      rd(99, d);
      chk("ramp_pre_last", 32'(d[23:12]), 32'hfff);
      rd(0, d);
      chk("ramp_first", 32'(d[23:12]), 32'hf9c);

      clear_gen();
      rand_gen();
      for (int k = 0; k < NG; k++) begin
         ga[k]  = DW'($urandom_range(0, 4094));
         gor[k] = 1'b0;
      end
      gf[AK]     = 1'b1;
      gf[AK + 5] = 1'b1;
      capture("force", 0, 1'b0, 1'b0, 12'h7ff);
      rd(0, d);
      chk("force_sample", 32'(d[23:12]), 32'(tc(ga[AK+3])));

      clear_gen();
      rand_gen();
      for (int k = 0; k < NG; k++) begin
         gb[k]  = (k < 1050) ? 12'ha00 : 12'h850;
         gor[k] = 1'b0;
      end
      capture("fall", 1023, 1'b1, 1'b1, 12'h100);
      rd(1023, d);
      chk("fall_after_step", 32'(d[11:0]), 32'h050);
      rd(1022, d);
      chk("fall_before_step", 32'(d[11:0]), 32'h200);

      clear_gen();
      rand_gen();
      for (int k = 0; k < NG; k++) gor[k] = 1'b0;
      gf[AK + 210]  = 1'b1;
      gor[AK + 260] = 1'b1;
      capture("ovr", 200, 1'b0, 1'b0,
              DW'($urandom_range(0, 4095)));
      chk("ovr_post_pulse", 32'(bus.ovr), 1);

      for (int r = 0; r < 3; r++) begin
         clear_gen();
         rand_gen();
         pre = $urandom_range(0, 1023);
         gf[AK + pre + $urandom_range(2, 40)] = 1'b1;
         arm2 = AK + $urandom_range(5, 50);
         capture("rnd", pre, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 4095)));
      end

      // reset while ARMED
      bus.adc_a      = 12'h000;
      bus.trig_ch    = 1'b0;
      bus.trig_edge  = 1'b0;
      bus.trig_level = 12'h7ff;
      bus.pre_len    = 10'd10;
      bus.arm        = 1'b1;
      tick();
      bus.arm = 1'b0;
      repeat (20) tick();
      chk("mid_busy", 32'(bus.busy), 1);
      #2 rstb = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 0);
      chk("mid_rst_done", 32'(bus.done), 0);
      chk("mid_rst_ready", 32'(bus.ready), 0);
      tick();
      rstb = 1'b1;
      for (int n = 1; n <= CFG; n++) begin
         tick();
         if (n == CFG - 1) chk("re_ready_low", 32'(bus.ready), 0);
         if (n == CFG) chk("re_ready_high", 32'(bus.ready), 1);
      end
      bus.adc_or = 1'b1;
      tick();
      bus.adc_or = 1'b0;
      repeat (4) tick();
      chk("idle_or_ignored", 32'(bus.ovr), 0);

      clear_gen();
      rand_gen();
      pre = $urandom_range(0, 1023);
      gf[AK + pre + 20] = 1'b1;
      capture("post_rst", pre, 1'b1, 1'b0,
              DW'($urandom_range(0, 4095)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ad9231_capture.md
Name: ad9231_capture

Overview:
- Downstream consumer of the AD9231 dual-channel ADC once the SPI configuration sequence has finished.
- Registers both 12-bit parallel channels and converts them from offset binary to two's complement.
- Runs a level/edge trigger on a selected channel and stores a pre/post-trigger window in an on-chip circular RAM.
- The processor side reads the window back, addressed from the window start, after done.

Parameters:
- DATA_W, 12, ADC sample width per channel.
- ADDR_W, 10, capture RAM address width; DEPTH = 2^ADDR_W samples per channel.
- CFG_WAIT, 20000, clk cycles after reset release before capture is permitted; covers completion of the SPI configuration writes.
- OFFSET_BIN, 1, 1 = invert MSB on input (offset binary to two's complement); 0 = pass through.

Ports:
- clk  in  1  ADC sample clock; all logic on posedge.
- rstb  in  1  asynchronous active-low reset.
- adc_a  in  DATA_W  channel A data bus.
- adc_b  in  DATA_W  channel B data bus.
- adc_or  in  1  ADC out-of-range flag.
- arm  in  1  single-cycle pulse that starts a capture.
- force_trig  in  1  pulse; triggers immediately in ARMED.
- trig_ch  in  1  trigger source: 0 = A, 1 = B.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_level  in  DATA_W  signed two's complement threshold.
- pre_len  in  ADDR_W  number of pre-trigger samples.
- rd_addr  in  ADDR_W  read offset relative to window start.
- rd_data  out  2*DATA_W  {chanA, chanB} at rd_addr, two's complement.
- ready  out  1  CFG_WAIT elapsed.
- busy  out  1  capture in progress (PRE, ARMED or POST).
- done  out  1  window complete and readable.
- ovr  out  1  sticky: adc_or seen during capture.
- trig_pos  out  ADDR_W  window offset of the trigger sample (equals clamped pre_len).

Behaviour:
- Reset values: rd_data=0, ready=0, busy=0, done=0, ovr=0, trig_pos=0, state=WAIT_CFG, write pointer=0, CFG_WAIT counter=0.
- Input stage:
  - adc_a, adc_b and adc_or are registered once (s1).
  - MSB is conditionally inverted into s2.
  - All trigger logic and RAM writes use s2, so latency from pin to RAM write is 2 clk.
  - Previous trigger-channel sample is held in s3 for edge detection.
- WAIT_CFG: counts to CFG_WAIT-1, then sets ready=1 (stays 1 until reset) and enters IDLE. arm is ignored in this state.
- IDLE:
  - On arm: clear done and ovr, latch pre_len (clamped to DEPTH-1 if greater), reset the PRE counter, set busy=1.
  - Go to PRE, or directly to ARMED if the latched pre_len is 0.
- PRE: write each s2 sample at wptr and increment wptr (mod DEPTH). After pre_len writes, go to ARMED. force_trig is ignored in PRE.
- ARMED: keep writing samples. The trigger fires on the cycle s2 satisfies one of:
  - rising: s3 < level and s2 >= level (signed);
  - falling: s3 > level and s2 <= level;
  - or force_trig = 1.
- On trigger:
  - The triggering sample is written and counts as post sample 1.
  - start_addr = wptr - pre_len (mod DEPTH) is latched, trig_pos = pre_len, and the state goes to POST.
- POST: writes a further DEPTH - pre_len - 1 samples, then goes to DONE. Total window = DEPTH samples; the trigger sample sits at offset pre_len.
- DONE: busy=0, done=1, RAM writes stop. arm restarts the capture exactly as in IDLE.
- arm while busy is ignored. Simultaneous arm and force_trig in IDLE: arm is taken, force_trig is ignored.
- ovr: set whenever s2-stage adc_or=1 while busy; cleared only by an accepted arm.
- Read:
  - Physical address = start_addr + rd_addr (mod DEPTH); rd_data is registered with 1 clk latency.
  - When done=0, rd_data is forced to 0.
  - rd_addr wraps naturally; no bounds error.
- rstb asserted mid-capture: all state returns to reset values, including WAIT_CFG (the ADC is reconfigured after reset). RAM contents are don't-care.

Test Plan:
- Release reset, hold arm high from cycle 0 → ready rises on cycle CFG_WAIT; no capture before then; busy stays 0 until the first arm after ready.
- Ramp on adc_a (offset binary 0x000..0xFFF, +1 per clk), trig_ch=0, rising, level=0 (signed), pre_len=100 → trigger on input 0x800; read rd_addr=100 → chanA=0x000; rd_addr=99 → 0xFFF (-1); rd_addr=0 → 0xF9C (-100); done after exactly 1024 writes from trigger-window start.
- pre_len=0, force_trig 5 clk after arm → trig_pos=0; rd_addr=0 holds the sample present at force_trig; ARMED skips PRE.
- pre_len=1023, falling edge, level=0x100, with a step from 0x200 to 0x050 (two's complement) → trigger on the step; rd_addr=1023 = 0x050; rd_addr=1022 = 0x200.
- adc_or pulsed for 1 clk during POST → ovr=1 after done; the next arm clears ovr to 0; a pulse while in IDLE leaves ovr=0.
- Assert rstb in ARMED → busy=0, done=0, ready=0 immediately; after release, ready returns after CFG_WAIT cycles.
